aximm_write_sequencer: RTL

Control block that owns the AW and B channels of the AXI4-slave write path and sequences the W-to-stream datapath beside it. It queues write-address commands, gates W beats one burst at a time, marks the final beat of each burst for AXIS_OUT_TLAST, and returns one B response per burst. WLAST is checked against AWLEN, and a mismatch is reported as SLVERR.

---
 rtl/aximm_write_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aximm_write_sequencer.sv
// aximm_write_sequencer
// Owns the AW and B channels of an AXI4-slave write path. Accepted write
// commands are queued, W beats are gated one burst at a time, the last beat of
// each burst is flagged for TLAST, and one B response per burst is returned in
// acceptance order. A WLAST that disagrees with AWLEN yields SLVERR.
module aximm_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          S_AXI_AWVALID,
  input  logic [IW-1:0] S_AXI_AWID,
  input  logic [7:0]    S_AXI_AWLEN,
  output logic          S_AXI_AWREADY,
  input  logic          S_AXI_WVALID,
  input  logic          S_AXI_WLAST,
  input  logic          AXIS_OUT_TREADY,
  output logic          W_GATE,
  output logic          BURST_END,
  output logic [IW-1:0] S_AXI_BID,
  output logic [1:0]    S_AXI_BRESP,
  output logic          S_AXI_BVALID,
  input  logic          S_AXI_BREADY,
  output logic [15:0]   ERR_COUNT
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] outst_reg;

  logic [IW-1:0] cmd_id_mem  [DEPTH];
  logic [7:0]    cmd_len_mem [DEPTH];
  logic [CW-1:0] cmd_wr_ptr_reg;
  logic [CW-1:0] cmd_rd_ptr_reg;

  logic [IW-1:0] b_id_mem   [DEPTH];
  logic [1:0]    b_resp_mem [DEPTH];
  logic [CW-1:0] b_wr_ptr_reg;
  logic [CW-1:0] b_rd_ptr_reg;

  logic [IW-1:0] cur_id_reg;
  logic [7:0]    cur_len_reg;
  logic [7:0]    beat_cnt_reg;
  logic          early_last_reg;
  logic [15:0]   err_count_reg;

  logic          aw_hs;
  logic          b_hs;
  logic          beat;
  logic          final_beat;
  logic          cmd_empty;
  logic          b_empty;
  logic [1:0]    push_resp;

  assign S_AXI_AWREADY = (outst_reg < DEPTH_C) & resetn;
  assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
  assign cmd_empty     = (cmd_wr_ptr_reg == cmd_rd_ptr_reg);
  assign b_empty       = (b_wr_ptr_reg == b_rd_ptr_reg);

  assign W_GATE     = (state_reg == ST_DATA);
  assign BURST_END  = W_GATE & (beat_cnt_reg == cur_len_reg);
  assign beat       = S_AXI_WVALID & W_GATE & AXIS_OUT_TREADY;
  assign final_beat = beat & BURST_END;
  // OKAY only when WLAST lands exactly on the AWLEN-defined final beat.
  assign push_resp  = (S_AXI_WLAST & ~early_last_reg) ? RESP_OKAY : RESP_SLVERR;

  // Head of the B queue is forced to zero while empty so idle outputs are clean.
  assign S_AXI_BVALID = ~b_empty;
  assign S_AXI_BID    = b_empty ? '0 : b_id_mem[b_rd_ptr_reg[PW-1:0]];
  assign S_AXI_BRESP  = b_empty ? '0 : b_resp_mem[b_rd_ptr_reg[PW-1:0]];
  assign b_hs         = S_AXI_BVALID & S_AXI_BREADY;
  assign ERR_COUNT    = err_count_reg;

  // Outstanding-burst accounting and command queue write pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      outst_reg      <= '0;
      cmd_wr_ptr_reg <= '0;
    end else begin
      if (aw_hs) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + CW'(1);
      if (aw_hs && !b_hs)      outst_reg <= outst_reg + CW'(1);
      else if (!aw_hs && b_hs) outst_reg <= outst_reg - CW'(1);
    end
  end

  // Command queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      cmd_id_mem[cmd_wr_ptr_reg[PW-1:0]]  <= S_AXI_AWID;
      cmd_len_mem[cmd_wr_ptr_reg[PW-1:0]] <= S_AXI_AWLEN;
    end
  end

  // W burst sequencer: one idle cycle to load a command, then gate beats.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      cmd_rd_ptr_reg <= '0;
      cur_id_reg     <= '0;
      cur_len_reg    <= '0;
      beat_cnt_reg   <= '0;
      early_last_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (!cmd_empty) begin
            cur_id_reg     <= cmd_id_mem[cmd_rd_ptr_reg[PW-1:0]];
            cur_len_reg    <= cmd_len_mem[cmd_rd_ptr_reg[PW-1:0]];
            cmd_rd_ptr_reg <= cmd_rd_ptr_reg + CW'(1);
            beat_cnt_reg   <= '0;
            early_last_reg <= 1'b0;
            state_reg      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (final_beat) begin
            state_reg <= ST_IDLE;
          end else if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            if (S_AXI_WLAST) early_last_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // B response queue pointers: push on a burst's final beat, pop on handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      b_wr_ptr_reg <= '0;
      b_rd_ptr_reg <= '0;
    end else begin
      if (final_beat) b_wr_ptr_reg <= b_wr_ptr_reg + CW'(1);
      if (b_hs)       b_rd_ptr_reg <= b_rd_ptr_reg + CW'(1);
    end
  end

  // B response queue storage.
  always_ff @(posedge clk) begin
    if (final_beat) begin
      b_id_mem[b_wr_ptr_reg[PW-1:0]]   <= cur_id_reg;
      b_resp_mem[b_wr_ptr_reg[PW-1:0]] <= push_resp;
    end
  end

  // Saturating count of SLVERR responses queued.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_count_reg <= '0;
    end else if (final_beat && (push_resp == RESP_SLVERR) && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

endmodule
